fifo_access_ctrl: RTL and testbench
===================================

Name: fifo_access_ctrl

Overview:
Controller owning both ports of the 8-bit tag FIFO. Two producers (RX demodulator path and command processor) share the write port through a round-robin arbiter. A burst-drain sequencer empties a requested number of bytes to the TX encoder. The block gates the FIFO enable so the FIFO idles when unused (low-power).

Parameters:
DATA_W, 8, FIFO word width
LEN_W, 5, width of burst length and count
IDLE_HOLD, 4, inactive cycles before fifo_en drops (1..15)

Ports:
clk  in  1  system clock; all state on rising edge
reset_n  in  1  asynchronous active-low reset
p0_valid  in  1  producer 0 has a word
p0_data  in  DATA_W  producer 0 word
p0_ready  out  1  producer 0 word accepted this cycle
p1_valid  in  1  producer 1 has a word
p1_data  in  DATA_W  producer 1 word
p1_ready  out  1  producer 1 word accepted this cycle
rd_req  in  1  start drain burst (sampled in IDLE only)
rd_len  in  LEN_W  burst length; 0 = drain until empty
rd_valid  out  1  rd_data valid
rd_data  out  DATA_W  drained word
rd_busy  out  1  burst in progress
rd_done  out  1  one-cycle pulse at burst end
rd_count  out  LEN_W  words delivered in current/last burst
fifo_en  out  1  FIFO enable
fifo_write  out  1  FIFO write strobe
fifo_data_in  out  DATA_W  FIFO write data
fifo_read  out  1  FIFO read strobe
fifo_data_out  in  DATA_W  FIFO read data, valid cycle after fifo_read
fifo_empty  in  1  FIFO empty flag
fifo_full  in  1  FIFO full flag

Behaviour:
- Reset (async, any time, incl. mid-burst): all outputs 0, FSM IDLE, RR pointer = p0, idle counter 0, rd_count 0. Partially drained data is not replayed.
- FIFO contract: write takes effect on edge where fifo_write=1 and fifo_full=0; fifo_data_out valid the cycle after fifo_read=1; flags updated on same edge.
- Enable: en_req = p0_valid | p1_valid | rd_req | rd_busy. fifo_en (registered) rises the cycle after en_req; falls after IDLE_HOLD consecutive cycles with en_req=0. No fifo_write/fifo_read while fifo_en=0; first access is one cycle after fifo_en rises.
- Write arbitration (combinational grant, registered pointer): eligible = fifo_en & !fifo_full. One valid -> it wins. Both valid -> the side not last served wins. fifo_write = eligible & winner valid; fifo_data_in = winner data, else 0. pX_ready = fifo_write & winner==X. Pointer updates only on a completed write.
- Producer holds valid/data until ready; dropping valid without ready is allowed.
- Read FSM: IDLE -> DRAIN on rd_req & fifo_en... rd_req in IDLE latches rd_len, clears rd_count, asserts rd_busy next cycle (rd_req while fifo_en=0 is held internally until fifo_en=1).
- DRAIN: fifo_read = !fifo_empty & (len==0 | issued<len). Exit to LAST when issued reaches len, or fifo_empty with no read this cycle (short burst).
- LAST: one cycle for final word; then DONE.
- DONE: rd_done=1 for one cycle, rd_busy=0, back to IDLE. rd_count keeps final value until next rd_req.
- rd_valid/rd_data: registered, rd_valid=1 the cycle after each fifo_read; rd_count increments with each rd_valid; saturates at all-ones when len=0.
- Simultaneous write and read in one cycle permitted. Write to full FIFO never issued; read from empty never issued.
- rd_req outside IDLE ignored.

Optional Feature:
FIFO_ARB_FIXED_PRIO_EN: defined -> p0 always wins when both valid; p1 served only when p0_valid=0; RR pointer removed. Undefined -> round-robin as above.

Test Plan:
- Reset: reset_n low mid-DRAIN with 3 words queued -> all outputs 0 immediately, FSM IDLE, fifo_en 0.
- Enable gating: p0_valid rises at cycle 0 (fifo_en 0) -> fifo_en=1 at cycle 1, first fifo_write cycle 1; after p0_valid drops, fifo_en falls after exactly 4 idle cycles.
- Round-robin: p0 and p1 both valid for 6 cycles with 0x55/0xAA -> writes alternate 0x55,0xAA,... (3 each); with FIFO_ARB_FIXED_PRIO_EN -> six 0x55.
- Full: fill 16-deep FIFO with 0x55 -> p0_ready stays 0 while full; one read frees slot -> exactly one more write.
- Burst: 8 words queued, rd_len=5 -> 5 rd_valid pulses in order, rd_count=5, rd_done pulse, 3 words remain.
- Short/unlimited burst: 3 words queued, rd_len=0 -> 3 words out, rd_done after empty, rd_count=3, no read while fifo_empty.

Source files
------------

// File: rtl/fifo_access_ctrl.sv
// Write-port arbiter, burst-drain sequencer and enable gating for the tag FIFO.
// Define FIFO_ARB_FIXED_PRIO_EN for fixed p0 priority instead of round-robin.
module fifo_access_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LEN_W     = 5,
  parameter int unsigned IDLE_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p0_valid,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_ready,
  input  logic              p1_valid,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_ready,
  input  logic              rd_req,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy,
  output logic              rd_done,
  output logic [LEN_W-1:0]  rd_count,
  output logic              fifo_en,
  output logic              fifo_write,
  output logic [DATA_W-1:0] fifo_data_in,
  output logic              fifo_read,
  input  logic [DATA_W-1:0] fifo_data_out,
  input  logic              fifo_empty,
  input  logic              fifo_full
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_LAST, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               en_q, en_d;
  logic [3:0]         idle_q, idle_d;
  logic               pend_q, pend_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   iss_q, iss_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               rdv_q;

  logic               busy, en_req, wr, rd, win1;

  // Arbitration: win1 selects producer 1 as the winner this cycle.
`ifdef FIFO_ARB_FIXED_PRIO_EN
  assign win1 = !p0_valid;
`else
  logic prio_q, prio_d;

  assign win1   = (p0_valid & p1_valid) ? prio_q : !p0_valid;
  assign prio_d = wr ? !win1 : prio_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prio_q <= 1'b0;
    else          prio_q <= prio_d;
  end
`endif

  assign wr           = en_q & !fifo_full & (p0_valid | p1_valid);
  assign fifo_write   = wr;
  assign fifo_data_in = wr ? (win1 ? p1_data : p0_data) : '0;
  assign p0_ready     = wr & !win1;
  assign p1_ready     = wr & win1;

  assign busy   = (state_q == S_DRAIN) || (state_q == S_LAST);
  assign en_req = p0_valid | p1_valid | rd_req | busy;
  assign rd     = (state_q == S_DRAIN) & en_q & !fifo_empty &
                  ((len_q == '0) | (iss_q < len_q));

  always_comb begin
    en_d   = en_q;
    idle_d = '0;
    if (en_req) begin
      en_d = 1'b1;
    end else if (en_q) begin
      if (idle_q == 4'(IDLE_HOLD - 1)) en_d = 1'b0;
      else                             idle_d = idle_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    len_d   = len_q;
    iss_d   = iss_q;
    cnt_d   = cnt_q;
    if (rdv_q && cnt_q != '1) cnt_d = cnt_q + LEN_W'(1);
    unique case (state_q)
      S_IDLE: begin
        // A request seen while the FIFO is gated off is parked until fifo_en rises.
        if (rd_req) begin
          len_d = rd_len;
          cnt_d = '0;
          if (en_q) begin
            state_d = S_DRAIN;
            pend_d  = 1'b0;
            iss_d   = '0;
          end else begin
            pend_d  = 1'b1;
          end
        end else if (pend_q && en_q) begin
          state_d = S_DRAIN;
          pend_d  = 1'b0;
          iss_d   = '0;
        end
      end
      S_DRAIN: begin
        if (rd) begin
          if (iss_q != '1) iss_d = iss_q + LEN_W'(1);
          if (len_q != '0 && (iss_q + LEN_W'(1)) == len_q) state_d = S_LAST;
        end else if (fifo_empty) begin
          state_d = S_LAST;
        end
      end
      S_LAST:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      idle_q  <= '0;
      pend_q  <= 1'b0;
      len_q   <= '0;
      iss_q   <= '0;
      cnt_q   <= '0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      idle_q  <= idle_d;
      pend_q  <= pend_d;
      len_q   <= len_d;
      iss_q   <= iss_d;
      cnt_q   <= cnt_d;
      rdv_q   <= rd;
    end
  end

  // The FIFO's read port is registered, so its output is the word in the cycle after fifo_read.
  assign rd_valid  = rdv_q;
  assign rd_data   = rdv_q ? fifo_data_out : '0;
  assign rd_busy   = busy;
  assign rd_done   = (state_q == S_DONE);
  assign rd_count  = cnt_q;
  assign fifo_en   = en_q;
  assign fifo_read = rd;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Self-checking bench for fifo_access_ctrl: behavioural 16-deep FIFO plus a cycle model of the controller.
module tb_fifo_access_ctrl;
  localparam int HOLD  = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       p0_valid = 1'b0, p1_valid = 1'b0, rd_req = 1'b0;
  logic [7:0] p0_data = '0, p1_data = '0;
  logic [4:0] rd_len = '0;
  logic       p0_ready, p1_ready, rd_valid, rd_busy, rd_done;
  logic [7:0] rd_data, fifo_data_in;
  logic [4:0] rd_count;
  logic       fifo_en, fifo_write, fifo_read;
  logic [7:0] fifo_data_out = '0;
  logic       fifo_empty = 1'b1, fifo_full = 1'b0;

  fifo_access_ctrl #(.DATA_W(8), .LEN_W(5), .IDLE_HOLD(HOLD)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_valid(p0_valid), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_data(p1_data), .p1_ready(p1_ready),
    .rd_req(rd_req), .rd_len(rd_len), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_busy(rd_busy), .rd_done(rd_done), .rd_count(rd_count),
    .fifo_en(fifo_en), .fifo_write(fifo_write), .fifo_data_in(fifo_data_in),
    .fifo_read(fifo_read), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [28:0] outs;
  assign outs = {p0_ready, p1_ready, rd_valid, rd_data, rd_busy, rd_done, rd_count,
                 fifo_en, fifo_write, fifo_data_in, fifo_read};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // FIFO storage; the controller's strobes are captured mid-cycle and applied on the edge.
  logic [7:0] q[$];
  logic       cap_w = 1'b0, cap_r = 1'b0;
  logic [7:0] cap_wd = '0;

  always @(posedge clk) begin : fifo_mdl
    bit wasfull;
    wasfull = (q.size() == DEPTH);
    if (cap_r && q.size() > 0) fifo_data_out <= q.pop_front();
    if (cap_w && !wasfull) q.push_back(cap_wd);
    fifo_empty <= (q.size() == 0);
    fifo_full  <= (q.size() == DEPTH);
  end

  // Controller model
  logic       m_en = 0, m_pref = 0, m_draining = 0, m_pend = 0, m_rdv = 0;
  int         m_idle = 0, m_tail = 0;
  logic [4:0] m_len = '0, m_issued = '0, m_count = '0;
  logic [7:0] m_exp_data = '0;

  always @(negedge clk) begin : cmp
    logic        e_w, e_r, e_busy, e_done, win, en_req;
    logic [7:0]  e_din, e_rdd;
    logic [28:0] e_outs;
    if (!reset_n) begin
      m_en = 0; m_pref = 0; m_draining = 0; m_pend = 0; m_rdv = 0;
      m_idle = 0; m_tail = 0; m_len = '0; m_issued = '0; m_count = '0; m_exp_data = '0;
      e_outs = '0;
      e_w = 0; e_r = 0; win = 0; e_busy = 0;
    end else begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
      win = !p0_valid;
`else
      win = (p0_valid && p1_valid) ? m_pref : !p0_valid;
`endif
      e_w    = m_en && !fifo_full && (p0_valid || p1_valid);
      e_din  = e_w ? (win ? p1_data : p0_data) : 8'h00;
      e_r    = m_draining && m_en && !fifo_empty && (m_len == 0 || m_issued < m_len);
      e_busy = m_draining || (m_tail == 2);
      e_done = (m_tail == 1);
      e_rdd  = m_rdv ? m_exp_data : 8'h00;
      e_outs = {e_w && !win, e_w && win, m_rdv, e_rdd, e_busy, e_done, m_count,
                m_en, e_w, e_din, e_r};
    end
    chk("cycle_outputs", 64'(outs), 64'(e_outs));
    cap_w  = fifo_write;
    cap_wd = fifo_data_in;
    cap_r  = fifo_read;
    if (reset_n) begin
      en_req = p0_valid || p1_valid || rd_req || e_busy;
      if (m_rdv && m_count != 5'd31) m_count++;
      m_rdv = e_r;
      if (e_r && q.size() > 0) m_exp_data = q[0];
      if (e_w) m_pref = !win;
      if (m_tail == 2) m_tail = 1;
      else if (m_tail == 1) m_tail = 0;
      else if (m_draining) begin
        if (e_r) begin
          if (m_issued != 5'd31) m_issued++;
          if (m_len != 0 && m_issued == m_len) begin m_draining = 0; m_tail = 2; end
        end else if (fifo_empty) begin
          m_draining = 0; m_tail = 2;
        end
      end else begin
        if (rd_req) begin
          m_len = rd_len; m_count = '0; m_issued = '0;
          if (m_en) begin m_draining = 1; m_pend = 0; end
          else m_pend = 1;
        end else if (m_pend && m_en) begin
          m_draining = 1; m_pend = 0; m_issued = '0;
        end
      end
      if (en_req) begin m_en = 1; m_idle = 0; end
      else if (m_en) begin
        m_idle++;
        if (m_idle == HOLD) begin m_en = 0; m_idle = 0; end
      end else m_idle = 0;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push(input int p, input logic [7:0] d0, input int n, input int inc);
    int done = 0;
    for (int g = 0; g < 200 && done < n; g++) begin
      if (p == 0) begin p0_valid = 1; p0_data = d0 + 8'(done * inc); end
      else        begin p1_valid = 1; p1_data = d0 + 8'(done * inc); end
      #1;
      if ((p == 0) ? p0_ready : p1_ready) done++;
      cyc();
    end
    p0_valid = 0; p1_valid = 0;
    chk("push_accepted", 64'(done), 64'(n));
  endtask

  logic [7:0] got[$];

  task automatic burst(input logic [4:0] len, input int expn, input string nm);
    bit seen_done = 0;
    got.delete();
    rd_req = 1; rd_len = len;
    for (int g = 0; g < 100 && !seen_done; g++) begin
      #1;
      if (rd_valid) got.push_back(rd_data);
      if (rd_done) seen_done = 1;
      cyc();
      rd_req = 0;
    end
    chk({nm, "_done"}, 64'(seen_done), 64'd1);
    chk({nm, "_words"}, 64'(got.size()), 64'(expn));
    chk({nm, "_count"}, 64'(rd_count), 64'(expn));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int n, wcount;
    logic [7:0] rv, exp8;
    repeat (3) cyc();
    chk("reset_outputs", 64'(outs), 64'd0);
    reset_n = 1;
    repeat (2) cyc();

    // Enable gating
    p0_valid = 1; p0_data = 8'h11;
    #1;
    chk("en_cycle0", 64'(fifo_en), 64'd0);
    chk("wr_cycle0", 64'(fifo_write), 64'd0);
    cyc();
    #1;
    chk("en_cycle1", 64'(fifo_en), 64'd1);
    chk("wr_cycle1", 64'({fifo_write, p0_ready, fifo_data_in}), 64'h311);
    cyc();
    p0_valid = 0;
    repeat (3) cyc();
    chk("en_hold3", 64'(fifo_en), 64'd1);
    cyc();
    chk("en_drop4", 64'(fifo_en), 64'd0);

    // Round-robin from a fresh pointer
    reset_n = 0;
    #1;
    chk("rr_reset", 64'(outs), 64'd0);
    cyc();
    reset_n = 1;
    cyc();
    p0_data = 8'h55; p1_data = 8'hAA; p0_valid = 1; p1_valid = 1;
    got.delete();
    n = 0;
    for (int g = 0; g < 30 && n < 6; g++) begin
      #1;
      if (fifo_write) begin got.push_back(fifo_data_in); n++; end
      cyc();
    end
    p0_valid = 0; p1_valid = 0;
    chk("rr_count", 64'(got.size()), 64'd6);
    for (int i = 0; i < 6 && i < got.size(); i++) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
      exp8 = 8'h55;
`else
      exp8 = (i % 2 == 1) ? 8'hAA : 8'h55;
`endif
      chk("rr_word", 64'(got[i]), 64'(exp8));
    end

    // Full FIFO: 1 + 6 queued, fill the remaining 9
    push(0, 8'h55, 9, 0);
    chk("fill_level", 64'(q.size()), 64'd16);
    p0_valid = 1; p0_data = 8'h55;
    repeat (3) begin
      #1;
      chk("full_no_ready", 64'({p0_ready, fifo_write}), 64'd0);
      cyc();
    end
    rd_req = 1; rd_len = 5'd1;
    wcount = 0; rv = '0;
    for (int g = 0; g < 8; g++) begin
      #1;
      if (p0_ready) wcount++;
      if (rd_valid) rv = rd_data;
      cyc();
      rd_req = 0;
    end
    p0_valid = 0;
    chk("full_one_more", 64'(wcount), 64'd1);
    chk("full_read_word", 64'(rv), 64'h11);
    chk("full_rd_count", 64'(rd_count), 64'd1);
    chk("full_level", 64'(q.size()), 64'd16);

    // Unlimited drain of all 16 words
    burst(5'd0, 16, "drain_all");
    chk("drain_all_empty", 64'(q.size()), 64'd0);

    // Length-limited burst; request issued while gated off
    push(1, 8'h80, 8, 1);
    repeat (8) cyc();
    chk("en_idle_off", 64'(fifo_en), 64'd0);
    burst(5'd5, 5, "burst5");
    if (got.size() == 5) begin
      chk("burst5_first", 64'(got[0]), 64'h80);
      chk("burst5_last", 64'(got[4]), 64'h84);
    end
    chk("burst5_left", 64'(q.size()), 64'd3);

    // Short burst ends on empty
    burst(5'd0, 3, "short");
    if (got.size() == 3) chk("short_last", 64'(got[2]), 64'h87);
    chk("short_left", 64'(q.size()), 64'd0);

    // Reset in the middle of a drain
    push(0, 8'h31, 3, 1);
    rd_req = 1; rd_len = 5'd0;
    cyc();
    rd_req = 0;
    chk("mid_busy", 64'(rd_busy), 64'd1);
    chk("mid_queued", 64'(q.size()), 64'd3);
    reset_n = 0;
    #1;
    chk("mid_reset_outs", 64'(outs), 64'd0);
    cyc();
    cyc();
    reset_n = 1;
    repeat (6) cyc();
    chk("post_reset_idle", 64'({rd_busy, fifo_en, rd_count}), 64'd0);
    chk("post_reset_left", 64'(q.size()), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
